// File: rtl/maindec_pkg.sv
// Shared constants and types for the multicycle LEGv8 main control unit.
// State encodings, opcode patterns, ALUOp values and exception causes live here.
package maindec_pkg;

    localparam int OPCODE_W = 11;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_EXEC_R   = 4'd2;
    localparam state_t S_WB_R     = 4'd3;
    localparam state_t S_MEM_ADDR = 4'd4;
    localparam state_t S_MEM_RD   = 4'd5;
    localparam state_t S_MEM_WB   = 4'd6;
    localparam state_t S_MEM_WR   = 4'd7;
    localparam state_t S_BRANCH   = 4'd8;
    localparam state_t S_EXC      = 4'd9;

    localparam logic [OPCODE_W-1:0] OP_LDUR    = 11'b11111000010;
    localparam logic [OPCODE_W-1:0] OP_STUR    = 11'b11111000000;
    localparam logic [OPCODE_W-1:0] OP_ADD     = 11'b10001011000;
    localparam logic [OPCODE_W-1:0] OP_SUB     = 11'b11001011000;
    localparam logic [OPCODE_W-1:0] OP_AND     = 11'b10001010000;
    localparam logic [OPCODE_W-1:0] OP_ORR     = 11'b10101010000;
    // CB-format opcodes carry three don't-care low bits
    localparam logic [OPCODE_W-1:0] OP_CB_MASK = 11'b11111111000;
    localparam logic [OPCODE_W-1:0] OP_CBZ     = 11'b10110100000;
    localparam logic [OPCODE_W-1:0] OP_CBNZ    = 11'b10110101000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_INVALID = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

    typedef struct packed {
        logic is_r;
        logic is_ld;
        logic is_st;
        logic is_cb;
        logic invalid;
    } opclass_t;

    typedef struct packed {
        logic       reg2loc;
        logic       alu_src;
        logic       memto_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       cbnz;
        logic       pc_write;
        logic       ir_write;
        logic       exc;
    } ctrl_t;

endpackage

// File: rtl/maindec_opclass.sv
// Combinational opcode classifier: maps the 11-bit opcode to an instruction class.
module maindec_opclass
    import maindec_pkg::*;
#(
    parameter int OP_W    = OPCODE_W,
    parameter bit EN_CBNZ = 1'b1
)(
    input  logic [OP_W-1:0] op,
    output opclass_t        cls
);

    logic cb_z;
    logic cb_nz;

    assign cb_z  = (op & OP_CB_MASK) == OP_CBZ;
    assign cb_nz = EN_CBNZ && ((op & OP_CB_MASK) == OP_CBNZ);

    always_comb begin
        cls         = '0;
        cls.is_r    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
        cls.is_ld   = (op == OP_LDUR);
        cls.is_st   = (op == OP_STUR);
        cls.is_cb   = cb_z || cb_nz;
        cls.invalid = !(cls.is_r || cls.is_ld || cls.is_st || cls.is_cb);
    end

endmodule

// File: rtl/maindec_fsm.sv
// Multicycle LEGv8 main control FSM with memory wait-state timeout,
// invalid-opcode/bus-timeout exceptions and a retired-instruction counter.
module maindec_fsm
    import maindec_pkg::*;
#(
    parameter int OP_W     = OPCODE_W,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32,
    parameter bit EN_CBNZ  = 1'b1
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             reg2loc,
    output logic             alu_src,
    output logic             memto_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic [1:0]       alu_op,
    output logic             cbnz,
    output logic             pc_write,
    output logic             ir_write,
    output logic             exc,
    output logic [1:0]       exc_cause,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    localparam int WC_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       cause_q, cause_d;
    opclass_t         cls;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;
    logic             retire;
    logic             timeout;

    maindec_opclass #(
        .OP_W    (OP_W),
        .EN_CBNZ (EN_CBNZ)
    ) u_opclass (
        .op  (op),
        .cls (cls)
    );

    assign timeout = !mem_ready && (wait_q == WC_W'(WAIT_MAX));

    // wait_d defaults to zero so any state change (or non-wait state) clears the counter
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        cause_d = cause_q;
        ctrl    = '0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.ir_write = 1'b1;
                    state_d       = S_DECODE;
                end else if (timeout) begin
                    state_d = S_EXC;
                    cause_d = EXC_TIMEOUT;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            S_DECODE: begin
                if (cls.is_r)                   state_d = S_EXEC_R;
                else if (cls.is_ld || cls.is_st) state_d = S_MEM_ADDR;
                else if (cls.is_cb)             state_d = S_BRANCH;
                else begin
                    state_d = S_EXC;
                    cause_d = EXC_INVALID;
                end
            end
            S_EXEC_R: begin
                ctrl.alu_op = ALUOP_RTYPE;
                state_d     = S_WB_R;
            end
            S_WB_R: begin
                ctrl.alu_op    = ALUOP_RTYPE;
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
                retire         = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALUOP_ADD;
                ctrl.reg2loc = cls.is_st;
                state_d      = cls.is_st ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl.alu_src  = 1'b1;
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_EXC;
                    cause_d = EXC_TIMEOUT;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            S_MEM_WB: begin
                ctrl.memto_reg = 1'b1;
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
                retire         = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg2loc   = 1'b1;
                ctrl.mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_EXC;
                    cause_d = EXC_TIMEOUT;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            S_BRANCH: begin
                ctrl.reg2loc = 1'b1;
                ctrl.alu_op  = ALUOP_PASSB;
                ctrl.branch  = 1'b1;
                ctrl.cbnz    = op[3];
                state_d      = S_FETCH;
                retire       = 1'b1;
            end
            S_EXC: begin
                ctrl.exc = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            cause_q   <= EXC_NONE;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    // Controls are forced low while reset is held, so an abandoned access drops at once
    assign ctrl_out  = reset_n ? ctrl : '0;
    assign reg2loc   = ctrl_out.reg2loc;
    assign alu_src   = ctrl_out.alu_src;
    assign memto_reg = ctrl_out.memto_reg;
    assign reg_write = ctrl_out.reg_write;
    assign mem_read  = ctrl_out.mem_read;
    assign mem_write = ctrl_out.mem_write;
    assign branch    = ctrl_out.branch;
    assign alu_op    = ctrl_out.alu_op;
    assign cbnz      = ctrl_out.cbnz;
    assign pc_write  = ctrl_out.pc_write;
    assign ir_write  = ctrl_out.ir_write;
    assign exc       = ctrl_out.exc;
    assign exc_cause = cause_q;
    assign state_o   = state_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_maindec_fsm.sv
// Directed table-driven bench for maindec_fsm (CNT_W=4 so counter wrap is reachable).
module tb_maindec_fsm;

    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_CBNZ = 11'b10110101000;
    localparam logic [10:0] T_CBZ  = 11'b10110100111;
    localparam logic [10:0] T_BAD  = 11'b00000000000;

    // bit order: reg2loc alu_src memto_reg reg_write mem_read mem_write branch alu_op[1:0] cbnz pc_write ir_write exc
    localparam logic [12:0] C_ZERO     = 13'b0_0_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] C_FETCH_GO = 13'b0_0_0_0_1_0_0_00_0_1_1_0;
    localparam logic [12:0] C_FETCH_WT = 13'b0_0_0_0_1_0_0_00_0_0_0_0;
    localparam logic [12:0] C_MADDR_LD = 13'b0_1_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] C_MADDR_ST = 13'b1_1_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] C_MEMRD    = 13'b0_1_0_0_1_0_0_00_0_0_0_0;
    localparam logic [12:0] C_MEMWB    = 13'b0_0_1_1_0_0_0_00_0_0_0_0;
    localparam logic [12:0] C_MEMWR    = 13'b1_1_0_0_0_1_0_00_0_0_0_0;
    localparam logic [12:0] C_EXECR    = 13'b0_0_0_0_0_0_0_10_0_0_0_0;
    localparam logic [12:0] C_WBR      = 13'b0_0_0_1_0_0_0_10_0_0_0_0;
    localparam logic [12:0] C_BR_NZ    = 13'b1_0_0_0_0_0_1_01_1_0_0_0;
    localparam logic [12:0] C_BR_Z     = 13'b1_0_0_0_0_0_1_01_0_0_0_0;
    localparam logic [12:0] C_EXC      = 13'b0_0_0_0_0_0_0_00_0_0_0_1;

    typedef struct {
        logic [10:0] op;
        logic        rdy;
        logic [3:0]  st;
        logic [12:0] ctrl;
        logic [3:0]  ret;
        logic [1:0]  cause;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] op = '0;
    logic        mem_ready = 1'b0;
    logic        reg2loc, alu_src, memto_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]  alu_op;
    logic        cbnz, pc_write, ir_write, exc;
    logic [1:0]  exc_cause;
    logic [3:0]  state_o;
    logic [3:0]  retired;
    logic [12:0] ctrl_v;

    int checks = 0;
    int errors = 0;
    vec_t vecs[33];

    always #5 clk = ~clk;

    maindec_fsm #(
        .OP_W     (11),
        .WAIT_MAX (15),
        .CNT_W    (4),
        .EN_CBNZ  (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .mem_ready (mem_ready),
        .reg2loc   (reg2loc),
        .alu_src   (alu_src),
        .memto_reg (memto_reg),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .branch    (branch),
        .alu_op    (alu_op),
        .cbnz      (cbnz),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .exc       (exc),
        .exc_cause (exc_cause),
        .state_o   (state_o),
        .retired   (retired)
    );

    assign ctrl_v = {reg2loc, alu_src, memto_reg, reg_write, mem_read, mem_write,
                     branch, alu_op, cbnz, pc_write, ir_write, exc};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle and checks the immediate response, then releases
    task automatic do_reset(input string tag);
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        #2;
        check({tag, "_rst_outputs"}, {51'd0, ctrl_v}, 64'd0);
        check({tag, "_rst_state_ret_cause"}, {54'd0, state_o, retired, exc_cause}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic run_add();
        op        = T_ADD;
        mem_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        vecs[0]  = '{T_LDUR, 1'b1, 4'd0, C_FETCH_GO, 4'd0, 2'd0};
        vecs[1]  = '{T_LDUR, 1'b1, 4'd1, C_ZERO,     4'd0, 2'd0};
        vecs[2]  = '{T_LDUR, 1'b1, 4'd4, C_MADDR_LD, 4'd0, 2'd0};
        vecs[3]  = '{T_LDUR, 1'b1, 4'd5, C_MEMRD,    4'd0, 2'd0};
        vecs[4]  = '{T_LDUR, 1'b1, 4'd6, C_MEMWB,    4'd0, 2'd0};
        vecs[5]  = '{T_ADD,  1'b1, 4'd0, C_FETCH_GO, 4'd1, 2'd0};
        vecs[6]  = '{T_ADD,  1'b1, 4'd1, C_ZERO,     4'd1, 2'd0};
        vecs[7]  = '{T_ADD,  1'b1, 4'd2, C_EXECR,    4'd1, 2'd0};
        vecs[8]  = '{T_ADD,  1'b1, 4'd3, C_WBR,      4'd1, 2'd0};
        vecs[9]  = '{T_CBNZ, 1'b1, 4'd0, C_FETCH_GO, 4'd2, 2'd0};
        vecs[10] = '{T_CBNZ, 1'b1, 4'd1, C_ZERO,     4'd2, 2'd0};
        vecs[11] = '{T_CBNZ, 1'b1, 4'd8, C_BR_NZ,    4'd2, 2'd0};
        vecs[12] = '{T_CBZ,  1'b1, 4'd0, C_FETCH_GO, 4'd3, 2'd0};
        vecs[13] = '{T_CBZ,  1'b1, 4'd1, C_ZERO,     4'd3, 2'd0};
        vecs[14] = '{T_CBZ,  1'b1, 4'd8, C_BR_Z,     4'd3, 2'd0};
        vecs[15] = '{T_STUR, 1'b1, 4'd0, C_FETCH_GO, 4'd4, 2'd0};
        vecs[16] = '{T_STUR, 1'b1, 4'd1, C_ZERO,     4'd4, 2'd0};
        vecs[17] = '{T_STUR, 1'b1, 4'd4, C_MADDR_ST, 4'd4, 2'd0};
        vecs[18] = '{T_STUR, 1'b0, 4'd7, C_MEMWR,    4'd4, 2'd0};
        vecs[19] = '{T_STUR, 1'b0, 4'd7, C_MEMWR,    4'd4, 2'd0};
        vecs[20] = '{T_STUR, 1'b0, 4'd7, C_MEMWR,    4'd4, 2'd0};
        vecs[21] = '{T_STUR, 1'b1, 4'd7, C_MEMWR,    4'd4, 2'd0};
        vecs[22] = '{T_BAD,  1'b1, 4'd0, C_FETCH_GO, 4'd5, 2'd0};
        vecs[23] = '{T_BAD,  1'b1, 4'd1, C_ZERO,     4'd5, 2'd0};
        vecs[24] = '{T_BAD,  1'b1, 4'd9, C_EXC,      4'd5, 2'd1};
        vecs[25] = '{T_BAD,  1'b0, 4'd0, C_FETCH_WT, 4'd5, 2'd1};
        vecs[26] = '{T_ORR,  1'b1, 4'd0, C_FETCH_GO, 4'd5, 2'd1};
        vecs[27] = '{T_ORR,  1'b1, 4'd1, C_ZERO,     4'd5, 2'd1};
        vecs[28] = '{T_ORR,  1'b1, 4'd2, C_EXECR,    4'd5, 2'd1};
        vecs[29] = '{T_ORR,  1'b1, 4'd3, C_WBR,      4'd5, 2'd1};
        vecs[30] = '{T_SUB,  1'b1, 4'd0, C_FETCH_GO, 4'd6, 2'd1};
        vecs[31] = '{T_SUB,  1'b1, 4'd1, C_ZERO,     4'd6, 2'd1};
        vecs[32] = '{T_SUB,  1'b1, 4'd2, C_EXECR,    4'd6, 2'd1};

        tick();
        do_reset("init");

        for (int i = 0; i < 33; i++) begin
            op        = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #2;
            check($sformatf("vec%0d_state_ret_cause", i),
                  {54'd0, state_o, retired, exc_cause},
                  {54'd0, vecs[i].st, vecs[i].ret, vecs[i].cause});
            check($sformatf("vec%0d_ctrl", i), {51'd0, ctrl_v}, {51'd0, vecs[i].ctrl});
            tick();
        end

        // Fetch times out after 16 consecutive not-ready cycles
        do_reset("tmo");
        for (int i = 0; i < 16; i++) begin
            mem_ready = 1'b0;
            #2;
            check($sformatf("tmo_wait%0d", i), {47'd0, state_o, ctrl_v}, {47'd0, 4'd0, C_FETCH_WT});
            tick();
        end
        #2;
        check("tmo_exc_state_ctrl", {47'd0, state_o, ctrl_v}, {47'd0, 4'd9, C_EXC});
        check("tmo_cause_ret", {58'd0, exc_cause, retired}, {58'd0, 2'd2, 4'd0});
        tick();
        #2;
        check("tmo_back_fetch", {58'd0, state_o, exc_cause}, {58'd0, 4'd0, 2'd2});

        // Ready arriving on the 16th wait cycle completes normally
        do_reset("late");
        for (int i = 0; i < 15; i++) begin
            mem_ready = 1'b0;
            tick();
        end
        mem_ready = 1'b1;
        #2;
        check("late_fetch_go", {51'd0, ctrl_v}, {51'd0, C_FETCH_GO});
        tick();
        #2;
        check("late_decode", {58'd0, state_o, exc_cause}, {58'd0, 4'd1, 2'd0});

        // Reset asserted during a stalled load read
        do_reset("mid");
        run_add();
        op        = T_LDUR;
        mem_ready = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;
        tick();
        #2;
        check("mid_memrd_wait", {47'd0, state_o, ctrl_v}, {47'd0, 4'd5, C_MEMRD});
        check("mid_ret_before", {60'd0, retired}, 64'd1);
        do_reset("mid");
        #2;
        check("mid_after_release", {47'd0, state_o, ctrl_v}, {47'd0, 4'd0, C_FETCH_WT});

        // 4-bit retired counter wraps after 16 instructions
        do_reset("wrap");
        for (int k = 0; k < 15; k++) run_add();
        #2;
        check("wrap_ret15", {60'd0, retired}, 64'd15);
        run_add();
        #2;
        check("wrap_ret0", {60'd0, retired}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
